// File: rtl/gate_tt_pkg.sv
// Shared definitions for the gate truth-table checker: op codes, FSM states, vector index width.
package gate_tt_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;
  localparam logic [2:0] OP_RSVD = 3'd7;

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/gate_tt_ref.sv
// Combinational expected-value model of the two-input gate block; reserved op yields 0.
module gate_tt_ref
  import gate_tt_pkg::*;
(
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y_exp
);

  always_comb begin
    y_exp = 1'b0;
    case (op)
      OP_AND:  y_exp = a & b;
      OP_OR:   y_exp = a | b;
      OP_NOT:  y_exp = ~a;
      OP_NAND: y_exp = ~(a & b);
      OP_NOR:  y_exp = ~(a | b);
      OP_XOR:  y_exp = a ^ b;
      OP_XNOR: y_exp = ~(a ^ b);
      default: y_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_tt_checker.sv
// Drives all four {A,B} vectors into a gate under test and checks Y against the selected function.
// Optional GATE_TT_YLOG_EN adds y_log, the raw Y sampled per vector.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output logic       a_out,
  output logic       b_out,
  input  logic       y_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic       err_op
`ifdef GATE_TT_YLOG_EN
  ,
  output logic [3:0] y_log
`endif
);

  localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(SETTLE_CYCLES);
  localparam state_e LP_AFTER_LOAD = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e           r_state;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pass;
  logic [3:0]       r_fail_mask;
  logic             r_err_op;

  logic             w_y_exp;
  logic             w_mismatch;
  logic [3:0]       w_mask_upd;

  gate_tt_ref u_ref (
    .op    (r_op),
    .a     (r_idx[1]),
    .b     (r_idx[0]),
    .y_exp (w_y_exp)
  );

  assign w_mismatch = y_in ^ w_y_exp;
  assign w_mask_upd = r_fail_mask | (4'(w_mismatch) << r_idx);

  // The vector index is the drive itself, so a_out/b_out come straight from a flop.
  assign a_out     = r_idx[1];
  assign b_out     = r_idx[0];
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;
  assign err_op    = r_err_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_AND;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pass      <= 1'b0;
      r_fail_mask <= 4'b0000;
      r_err_op    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_fail_mask <= 4'b0000;
            r_pass      <= 1'b0;
            if (op == OP_RSVD) begin
              r_err_op <= 1'b1;
              r_state  <= ST_DONE;
            end else begin
              r_err_op <= 1'b0;
              r_op     <= op;
              r_idx    <= '0;
              r_cnt    <= LP_RELOAD;
              r_state  <= LP_AFTER_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_fail_mask <= w_mask_upd;
          if (r_idx == IDX_W'(3)) begin
            // pass is resolved here so it is already valid during the done cycle
            r_pass  <= (w_mask_upd == 4'b0000) && !r_err_op;
            r_state <= ST_DONE;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_cnt   <= LP_RELOAD;
            r_state <= LP_AFTER_LOAD;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_TT_YLOG_EN
  logic [3:0] r_ylog;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ylog <= 4'b0000;
    end else if (r_state == ST_IDLE && start) begin
      r_ylog <= 4'b0000;
    end else if (r_state == ST_SAMPLE) begin
      r_ylog[r_idx] <= y_in;
    end
  end

  assign y_log = r_ylog;
`endif

endmodule

// File: tb/tb_gate_tt_checker.sv
// Directed bench for gate_tt_checker: SETTLE_CYCLES=2 instance plus a SETTLE_CYCLES=0 instance.
module tb_gate_tt_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, start2, y_in, y_in2;
  logic [2:0] op, op2;
  logic       a_out, b_out, busy, done, pass, err_op;
  logic       a_out2, b_out2, busy2, done2, pass2, err_op2;
  logic [3:0] fail_mask, fail_mask2;
`ifdef GATE_TT_YLOG_EN
  logic [3:0] y_log, y_log2;
`endif

  // 0 AND, 1 OR, 2 NOT A, other: tied low
  int mode;
  always_comb begin
    y_in = 1'b0;
    case (mode)
      0: y_in = a_out & b_out;
      1: y_in = a_out | b_out;
      2: y_in = ~a_out;
      default: y_in = 1'b0;
    endcase
  end
  assign y_in2 = 1'b0;

  gate_tt_checker #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a_out(a_out), .b_out(b_out), .y_in(y_in),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .err_op(err_op)
`ifdef GATE_TT_YLOG_EN
    , .y_log(y_log)
`endif
  );

  gate_tt_checker #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start2), .op(op2),
    .a_out(a_out2), .b_out(b_out2), .y_in(y_in2),
    .busy(busy2), .done(done2), .pass(pass2),
    .fail_mask(fail_mask2), .err_op(err_op2)
`ifdef GATE_TT_YLOG_EN
    , .y_log(y_log2)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a run on dut, scramble op while busy, wait (bounded) for done.
  task automatic run1(input logic [2:0] o, input int m, output int cyc);
    mode  = m;
    op    = o;
    start = 1'b1;
    tick();
    start = 1'b0;
    op    = o ^ 3'd1;
    cyc   = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    bit  ok;
    rst = 1'b1; start = 1'b1; op = 3'd0; mode = 0;
    start2 = 1'b0; op2 = 3'd0;

    // Reset with start held high
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_mask", 32'(fail_mask), 32'd0);
    chk("rst_err", 32'(err_op), 32'd0);
    chk("rst_ab", 32'({a_out, b_out}), 32'd0);
    chk("rst_busy0", 32'(busy2), 32'd0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("no_run_after_rst", 32'(busy), 32'd0);

    // AND with a correct AND model: vector sequence and latency
    mode = 0; op = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      if ({a_out, b_out} != 2'((c - 1) / 3)) ok = 1'b0;
      if (done || !busy) ok = 1'b0;
      tick();
    end
    chk("and_vec_seq", 32'(ok), 32'd1);
    chk("and_done_c13", 32'(done), 32'd1);
    chk("and_busy_done", 32'(busy), 32'd1);
    chk("and_pass", 32'(pass), 32'd1);
    chk("and_mask", 32'(fail_mask), 32'd0);
    tick();
    chk("and_done_pulse", 32'(done), 32'd0);
    chk("and_idle", 32'(busy), 32'd0);
    chk("and_hold_ab", 32'({a_out, b_out}), 32'd3);
    chk("and_hold_pass", 32'(pass), 32'd1);

    // XOR checked against an OR gate: only vector 3 differs
    run1(3'd5, 1, cyc);
    chk("xor_done_cyc", 32'(cyc), 32'd13);
    chk("xor_mask", 32'(fail_mask), 32'h8);
    chk("xor_pass", 32'(pass), 32'd0);
    chk("xor_err", 32'(err_op), 32'd0);
`ifdef GATE_TT_YLOG_EN
    chk("xor_ylog", 32'(y_log), 32'he);
`endif
    tick();

    // NOT-A, then back-to-back reserved op
    run1(3'd2, 2, cyc);
    chk("not_done_cyc", 32'(cyc), 32'd13);
    chk("not_pass", 32'(pass), 32'd1);
    chk("not_mask", 32'(fail_mask), 32'd0);
    tick();
    run1(3'd7, 0, cyc);
    chk("rsvd_done_cyc", 32'(cyc), 32'd1);
    chk("rsvd_err", 32'(err_op), 32'd1);
    chk("rsvd_pass", 32'(pass), 32'd0);
    chk("rsvd_mask", 32'(fail_mask), 32'd0);
    chk("rsvd_ab", 32'({a_out, b_out}), 32'd3);
    tick();
    chk("rsvd_err_hold", 32'(err_op), 32'd1);

    // Reset during SAMPLE of vector 1 (NOR vs AND model: vector 0 already failed)
    mode = 0; op = 3'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("abort_in_v1", 32'({a_out, b_out}), 32'd1);
    chk("abort_mask_pre", 32'(fail_mask), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_mask", 32'(fail_mask), 32'd0);
    chk("abort_ab", 32'({a_out, b_out}), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    ok = 1'b0;
    repeat (15) begin
      tick();
      if (done || busy) ok = 1'b1;
    end
    chk("abort_no_done", 32'(ok), 32'd0);
    run1(3'd0, 0, cyc);
    chk("fresh_done_cyc", 32'(cyc), 32'd13);
    chk("fresh_pass", 32'(pass), 32'd1);
    tick();

    // SETTLE_CYCLES=0, XNOR with Y tied low, start pulsed mid-run
    op2 = 3'd6; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("z_busy_c1", 32'(busy2), 32'd1);
    tick();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick();
    chk("z_done_c5", 32'(done2), 32'd1);
    chk("z_mask", 32'(fail_mask2), 32'h9);
    chk("z_pass", 32'(pass2), 32'd0);
`ifdef GATE_TT_YLOG_EN
    chk("z_ylog", 32'(y_log2), 32'h0);
`endif
    tick();
    chk("z_no_restart", 32'(busy2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
